// File: rtl/seg_scan_driver_if.sv
// Bus between the datapath and the 7-segment scan driver.
// Handshake: load is a valid-only strobe with no ready; data is captured on
// every rising edge where load=1 and the driver can never stall the writer.
// Display pins (seg, an, frame_tick) are driver outputs and are always valid.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic [NUM_DIGITS-1:0]     blink;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_tick;

    modport master (
        output enable, load, data, digit_en, blink,
        input  seg, an, frame_tick
    );

    modport slave (
        input  enable, load, data, digit_en, blink,
        output seg, an, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit hex 7-segment driver.
// A prescaler divides each digit slot into SCAN_DIV cycles; the first cycle of
// every slot is blanked to avoid ghosting. Loaded values sit in a pending
// register and are applied only at frame wrap, so a frame never tears; the very
// first load after reset is shown at once.
// Optional feature macro: SEG_BLINK_EN (per-digit blinking, BLINK_FRAMES frames
// per half-period). Without it the blink input is ignored.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DW-1:0]         shown_q, shown_d;
    logic                  loaded_q, loaded_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  slot_last;
    logic                  frame_wrap;
    logic                  blink_hide;

    assign slot_last  = (presc_q == PRE_LAST);
    assign frame_wrap = bus.enable && slot_last && (idx_q == IDX_LAST);

    // Fixed hex font, seg[6:0] = {a,b,c,d,e,f,g}.
    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h00;
        case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            4'hF: s = 7'h47;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

`ifdef SEG_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;

    // Frame counter: toggles blink phase every BLINK_FRAMES frame wraps.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_wrap) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Blink state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_hide = phase_q & bus.blink[idx_q];
`else
    logic unused_blink;
    assign unused_blink = ^bus.blink;
    assign blink_hide   = 1'b0;
`endif

    // Scan position, shadowed display value and next registered outputs.
    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        shown_d      = shown_q;
        loaded_d     = loaded_q;
        seg_d        = 7'h00;
        an_d         = '0;
        tick_d       = 1'b0;

        if (bus.enable) begin
            if (slot_last) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            tick_d = frame_wrap;
            // First cycle of a slot is the anti-ghosting gap.
            if ((presc_q != '0) && bus.digit_en[idx_q] && !blink_hide) begin
                an_d  = NUM_DIGITS'(1) << idx_q;
                seg_d = font(shown_q[{idx_q, 2'b00} +: 4]);
            end
        end

        // Wrap applies the value pending before this edge; a load on the same
        // edge lands in pending for the next wrap.
        if (frame_wrap && pend_valid_q) begin
            shown_d      = pend_q;
            pend_valid_d = 1'b0;
        end

        if (bus.load) begin
            if (!loaded_q) begin
                shown_d  = bus.data;
                loaded_d = 1'b1;
            end else begin
                pend_d       = bus.data;
                pend_valid_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            shown_q      <= '0;
            loaded_q     <= 1'b0;
            seg_q        <= 7'h00;
            an_q         <= '0;
            tick_q       <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            shown_q      <= shown_d;
            loaded_q     <= loaded_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            tick_q       <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver: directed steps plus a randomized phase,
// checked every cycle against a position-based reference model.
module tb_seg_scan_driver;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [6:0] font_tbl [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: scan position is the count of enabled cycles since reset.
    int            pos;
    logic [15:0]   m_pend;
    logic [15:0]   m_shown;
    bit            m_pend_v;
    bit            m_loaded;

    task automatic model_reset();
        pos      = 0;
        m_pend   = '0;
        m_shown  = '0;
        m_pend_v = 1'b0;
        m_loaded = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        chk_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h (pos %0d)", tag, got, exp, pos);
    endtask

    // One clock: predict from pre-edge state/inputs, advance, compare.
    task automatic step();
        logic [6:0]    e_seg;
        logic [ND-1:0] e_an;
        logic          e_tick;
        bit            wrap;
        bit            hide;
        bit            ld;
        logic [15:0]   dat;
        int            off;
        int            slot;
        e_seg  = '0;
        e_an   = '0;
        e_tick = 1'b0;
        wrap   = 1'b0;
        hide   = 1'b0;
        ld     = bus.load;
        dat    = bus.data;
        if (rst_n && bus.enable) begin
            off  = pos % SD;
            slot = (pos / SD) % ND;
            wrap = (pos % FRAME) == FRAME - 1;
`ifdef SEG_BLINK_EN
            hide = ((((pos / FRAME) / BF) % 2) == 1) && bus.blink[slot];
`endif
            e_tick = wrap;
            if (off != 0 && bus.digit_en[slot] && !hide) begin
                e_an  = ND'(1) << slot;
                e_seg = font_tbl[m_shown[4*slot +: 4]];
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (bus.enable) pos = pos + 1;
            if (wrap && m_pend_v) begin
                m_shown  = m_pend;
                m_pend_v = 1'b0;
            end
            if (ld) begin
                if (!m_loaded) begin
                    m_shown  = dat;
                    m_loaded = 1'b1;
                end else begin
                    m_pend   = dat;
                    m_pend_v = 1'b1;
                end
            end
        end
        check("seg", 16'(bus.seg), 16'(e_seg));
        check("an", 16'(bus.an), 16'(e_an));
        check("frame_tick", 16'(bus.frame_tick), 16'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_once(input logic [15:0] d);
        bus.load = 1'b1;
        bus.data = d;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.data     = '0;
        bus.digit_en = '0;
        bus.blink    = '0;

        // Reset state.
        run(3);
        rst_n = 1'b1;

        // Plan 1: first load shows immediately, full scan of 0x12AF.
        bus.enable   = 1'b1;
        bus.digit_en = 4'hF;
        load_once(16'h12AF);
        run(2 * FRAME + 5);

        // Plan 2: mid-frame load only takes effect at next frame.
        load_once(16'h0000);
        run(2 * FRAME);

        // Plan 3: pending value plus a load coinciding with the wrap.
        run(3);
        load_once(16'h5555);
        guard = 0;
        while ((pos % FRAME) != FRAME - 1 && guard < 100) begin
            step();
            guard++;
        end
        check("wrap_align_timeout", 16'(guard < 100), 16'(1));
        load_once(16'h8888);
        run(2 * FRAME + 2);

        // Plan 4: disabled digits and an enable gap.
        bus.digit_en = 4'b0101;
        run(2 * FRAME);
        bus.enable = 1'b0;
        run(10);
        bus.enable = 1'b1;
        run(FRAME + 3);
        bus.digit_en = 4'hF;

        // Plan 5: async reset mid-slot at index 2.
        guard = 0;
        while (!(((pos / SD) % ND) == 2 && (pos % SD) == 2) && guard < 100) begin
            step();
            guard++;
        end
        check("idx2_align_timeout", 16'(guard < 100), 16'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", 16'(bus.seg), 16'(0));
        check("async_rst_an", 16'(bus.an), 16'(0));
        check("async_rst_tick", 16'(bus.frame_tick), 16'(0));
        model_reset();
        #1;
        rst_n = 1'b1;
        load_once(16'h1234);
        run(FRAME + 4);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            bus.enable   = ($urandom_range(0, 9) != 0);
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.data     = 16'($urandom);
            if ($urandom_range(0, 15) == 0) bus.digit_en = ND'($urandom);
            bus.blink    = ND'($urandom);
            step();
        end
        bus.load = 1'b0;

        // Plan 6: blink on digit 0 over several frames.
        bus.enable   = 1'b1;
        bus.digit_en = 4'hF;
        bus.blink    = 4'b0001;
        run(6 * FRAME);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised, time-multiplexed multi-digit 7-segment display driver. It holds a multi-digit hex value and scans one digit at a time, rotating a one-hot anode select. Each selected nibble is decoded to segments with a fixed hex font. The block sits between the datapath, which writes display words, and the board's common-anode/segment pins, and replaces the per-digit combinational decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 1000, clock cycles per digit slot; legal range 2..65535.
- BLINK_FRAMES, 64, full frames per blink half-period; used only with SEG_BLINK_EN.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, scan enable.
- load, input, 1, one-cycle strobe that captures data.
- data, input, 4*NUM_DIGITS, hex value; nibble k drives digit k, with digit 0 at LSBs.
- digit_en, input, NUM_DIGITS, per-digit enable; 0 blanks that digit.
- blink, input, NUM_DIGITS, per-digit blink request; ignored unless SEG_BLINK_EN is defined.
- seg, output, 7, segments {a,b,c,d,e,f,g} = seg[6:0]; active-high, 1 = lit.
- an, output, NUM_DIGITS, one-hot digit select; active-high.
- frame_tick, output, 1, one-cycle pulse at the end of every full scan frame.

Behaviour:
- Reset (async assert, sync release): prescaler=0, index=0, pending register=0, pending_valid=0, shown register=0, seg=0, an=0, frame_tick=0.
- Prescaler counts 0..SCAN_DIV-1 while enable=1.
  - At SCAN_DIV-1 it wraps to 0 and index advances by 1.
  - index wraps from NUM_DIGITS-1 to 0.
- frame_tick is registered. It is 1 for exactly one cycle, in the cycle after prescaler=SCAN_DIV-1 and index=NUM_DIGITS-1.
- Outputs are registered with one-cycle latency from (index, prescaler). On the next edge:
  - Blank slot start (prescaler==0): an=0, seg=0. This anti-ghosting gap is 1 cycle per slot.
  - Otherwise, if digit_en[index]=1: an=1<<index, seg=font(shown[4*index+3:4*index]).
  - Otherwise (digit_en[index]=0): an=0, seg=0. The slot is still consumed for its full length.
- Font (hex, seg[6:0]): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- Load and shadowing:
  - load=1 captures data into the pending register and sets pending_valid.
  - At each frame wrap (the cycle that sets frame_tick), if pending_valid, shown<=pending and pending_valid is cleared. The display therefore never tears mid-frame.
  - Exception: the very first load after reset is copied to shown immediately, on the following edge.
- Simultaneous load and frame wrap:
  - The wrap copies the pending value held before this edge, if valid.
  - The new data lands in pending with pending_valid=1, to be applied at the next wrap.
- Back-to-back loads within a frame: the last one wins.
- enable=0:
  - prescaler, index and blink state hold.
  - seg=0, an=0 and frame_tick=0 from the next edge.
  - load still operates.
  - Scanning resumes from the held position when enable returns to 1.
- rst_n asserted mid-frame: all state returns to reset values immediately, including pending data, which is discarded.
- NUM_DIGITS=1: index stays 0, and frame_tick pulses every SCAN_DIV cycles.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - A frame counter counts frame_tick pulses 0..BLINK_FRAMES-1, then wraps and toggles blink_phase (reset 0).
  - While blink_phase=1, any digit with blink[k]=1 is driven as blanked (an=0, seg=0) for its whole slot.
  - enable=0 freezes the frame counter and blink_phase.
- Undefined:
  - No frame counter and no blink_phase are implemented.
  - The blink port exists but is ignored, and its value has no effect on outputs.

Test Plan:
1. Reset release, NUM_DIGITS=4, SCAN_DIV=4, enable=1, digit_en=F, load data=0x12AF -> digits 0..3 are shown in turn:
   - digit 0: an=0001, seg=47 for 3 cycles after 1 blank cycle;
   - digit 1: an=0010, seg=77;
   - digit 2: an=0100, seg=6D;
   - digit 3: an=1000, seg=30;
   - frame_tick pulses every 16 cycles.
2. Mid-frame load 0x0000 while 0x12AF is showing -> remaining digits of the current frame still show 0x12AF. From the next frame every enabled slot shows seg=7E.
3. load asserted in the same cycle as the frame wrap with data 0x8888 -> the following frame shows the previous pending value (or the unchanged value if none was pending); the frame after that shows seg=7F on all digits.
4. digit_en=0101 -> slots 1 and 3 hold an=0, seg=0 for 4 cycles each, and frame_tick period stays 16 cycles. enable=0 for 10 cycles then 1 -> an=0, seg=0 and no frame_tick during the gap; scan resumes at the same index and prescaler value.
5. rst_n pulsed low mid-slot at index 2 -> an, seg and frame_tick go to 0 without a clock edge. After release, the first post-reset load (for example 0x1234) shows immediately: digit 0 seg=33 in the first slot.
6. With SEG_BLINK_EN, BLINK_FRAMES=2, blink=0001 -> digit 0 is dark for frames 2-3 and lit for frames 4-5, while digits 1-3 are unaffected. Without the macro, the same stimulus shows no blanking.
